// File: rtl/ignition_gear_ctrl.sv
// rtl/ignition_gear_ctrl.sv - ignition FSM (OFF/ACC/CRANK/RUN) and P/R/N/D gear selector; optional AUTO_PARK_EN
module ignition_gear_ctrl #(
  parameter int SPD_W       = 8,
  parameter int FUEL_W      = 8,
  parameter int MAX_GEAR    = 3,
  parameter int LIM_W       = 3,
  parameter int CRANK_TICKS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              key_start,
  input  logic              key_brake,
  input  logic              key_park,
  input  logic              key_neutral,
  input  logic              key_rev,
  input  logic              key_drive,
  input  logic              low_mode,
  input  logic              lim_up,
  input  logic              lim_dn,
  input  logic [SPD_W-1:0]  speed,
  input  logic [FUEL_W-1:0] fuel,
  output logic [1:0]        power_state,
  output logic              engine_on,
  output logic              acc_on,
  output logic              crank_busy,
  output logic [3:0]        gear_sel,
  output logic [LIM_W-1:0]  gear_limit,
  output logic              fault_nofuel
);

  // Encodings double as the external power_state codes.
  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_ACC   = 2'd1,
    S_RUN   = 2'd2,
    S_CRANK = 2'd3
  } pstate_t;

  // Gear codes are the display codes consumed downstream.
  localparam logic [3:0] GEAR_P = 4'd3;
  localparam logic [3:0] GEAR_R = 4'd6;
  localparam logic [3:0] GEAR_N = 4'd9;
  localparam logic [3:0] GEAR_D = 4'd12;

  localparam int CNT_W = (CRANK_TICKS > 1) ? $clog2(CRANK_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CRANK_TICKS - 1);
  localparam logic [LIM_W-1:0] LIM_MAX   = LIM_W'(MAX_GEAR);
  localparam logic [LIM_W-1:0] LIM_MIN   = LIM_W'(1);

  pstate_t          state;
  pstate_t          state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             fault_next;
  logic             prev_start;
  logic             prev_up;
  logic             prev_dn;
  logic [3:0]       gear_next;
  logic [LIM_W-1:0] limit_next;

  logic start_edge;
  logic up_edge;
  logic dn_edge;
  logic ready;
  logic fuel_ok;
  logic stopped;
  logic leave_ok;
  logic run_to_off;

  // Start is sampled on the tick grid, lim keys on every clock.
  assign start_edge = key_start & ~prev_start;
  assign up_edge    = lim_up & ~prev_up;
  assign dn_edge    = lim_dn & ~prev_dn;
  assign ready      = key_brake & (gear_sel == GEAR_P);
  assign fuel_ok    = (fuel != '0);
  assign stopped    = (speed == '0);
  assign leave_ok   = (gear_sel != GEAR_P) | key_brake;
  assign run_to_off = tick & (state == S_RUN) & (state_next == S_OFF);

  assign power_state = state;
  assign engine_on   = (state == S_RUN);
  assign acc_on      = (state != S_OFF);
  assign crank_busy  = (state == S_CRANK);

  // Ignition state, crank counter, sticky fuel fault and start-key history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_OFF;
      cnt          <= '0;
      fault_nofuel <= 1'b0;
      prev_start   <= 1'b1;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      fault_nofuel <= fault_next;
      if (tick) begin
        prev_start <= key_start;
      end
    end
  end

  // Next ignition state; nothing moves between ticks.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    fault_next = fault_nofuel;
    if (tick) begin
      if (fuel_ok) begin
        fault_next = 1'b0;
      end
      case (state)
        S_OFF: begin
          if (start_edge) begin
            state_next = (ready && fuel_ok) ? S_CRANK : S_ACC;
          end
        end
        S_ACC: begin
          if (start_edge) begin
            if (!ready) begin
              state_next = S_OFF;
            end else if (fuel_ok) begin
              state_next = S_CRANK;
            end
          end
        end
        S_CRANK: begin
          // Abort is checked first so it beats a completing count.
          if (!key_brake || !fuel_ok) begin
            state_next = S_ACC;
            cnt_next   = '0;
          end else if (cnt == CNT_LAST) begin
            state_next = S_RUN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (!fuel_ok) begin
            state_next = S_ACC;
            fault_next = 1'b1;
          end else if (start_edge && stopped) begin
            state_next = S_OFF;
          end
        end
        default: begin
          state_next = S_OFF;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Gear selector, gear limit and limit-key history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gear_sel   <= GEAR_P;
      gear_limit <= LIM_MAX;
      prev_up    <= 1'b1;
      prev_dn    <= 1'b1;
    end else begin
      gear_sel   <= gear_next;
      gear_limit <= limit_next;
      prev_up    <= lim_up;
      prev_dn    <= lim_dn;
    end
  end

  // Gear request arbitration: park > neutral > low_mode > rev > drive.
  always_comb begin
    gear_next  = gear_sel;
    limit_next = gear_limit;
    if (key_park) begin
      gear_next = GEAR_P;
    end else if (key_neutral) begin
      gear_next = GEAR_N;
    end else if (low_mode) begin
      if (up_edge) begin
        if (gear_limit < LIM_MAX) begin
          limit_next = gear_limit + 1'b1;
        end
      end else if (dn_edge) begin
        if (gear_limit > LIM_MIN) begin
          limit_next = gear_limit - 1'b1;
        end
      end
    end else if (key_rev) begin
      if (stopped && leave_ok) begin
        gear_next = GEAR_R;
      end
    end else if (key_drive) begin
      if (stopped && leave_ok) begin
        gear_next = GEAR_D;
      end
    end
`ifdef AUTO_PARK_EN
    // Switching off from RUN parks the vehicle regardless of gear keys.
    if (run_to_off) begin
      gear_next = GEAR_P;
    end
`else
    if (run_to_off) begin
      gear_next = gear_next;
    end
`endif
  end

endmodule

// File: tb/tb_ignition_gear_ctrl.sv
// tb/tb_ignition_gear_ctrl.sv - self-checking bench for ignition_gear_ctrl
module tb_ignition_gear_ctrl;

  localparam int P_OFF = 0, P_ACC = 1, P_RUN = 2, P_CRANK = 3;
  localparam int G_P = 3, G_R = 6, G_N = 9, G_D = 12;
  localparam int MAXG = 3, CRANKS = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick = 1'b0, key_start = 1'b0, key_brake = 1'b0;
  logic key_park = 1'b0, key_neutral = 1'b0, key_rev = 1'b0, key_drive = 1'b0;
  logic low_mode = 1'b0, lim_up = 1'b0, lim_dn = 1'b0;
  logic [7:0] speed = 8'd0, fuel = 8'd0;
  logic [1:0] power_state;
  logic engine_on, acc_on, crank_busy, fault_nofuel;
  logic [3:0] gear_sel;
  logic [2:0] gear_limit;

  int checks = 0;
  int errors = 0;

  // Reference model: what the vehicle should be doing, in plain integers.
  int m_ps, m_crank_done, m_fault, m_gear, m_lim;
  bit m_start_prev, m_up_prev, m_dn_prev;

  ignition_gear_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .key_start(key_start), .key_brake(key_brake),
    .key_park(key_park), .key_neutral(key_neutral), .key_rev(key_rev), .key_drive(key_drive),
    .low_mode(low_mode), .lim_up(lim_up), .lim_dn(lim_dn), .speed(speed), .fuel(fuel),
    .power_state(power_state), .engine_on(engine_on), .acc_on(acc_on), .crank_busy(crank_busy),
    .gear_sel(gear_sel), .gear_limit(gear_limit), .fault_nofuel(fault_nofuel)
  );

  always #5 clk = ~clk;

  function automatic int expected_auto_park_gear(input int held);
`ifdef AUTO_PARK_EN
    return G_P;
`else
    return held;
`endif
  endfunction

  function automatic logic [12:0] model_vec();
    logic [12:0] v;
    v = {2'(m_ps), (m_ps == P_RUN), (m_ps != P_OFF), (m_ps == P_CRANK),
         4'(m_gear), 3'(m_lim), (m_fault != 0)};
    return v;
  endfunction

  function automatic logic [12:0] dut_vec();
    return {power_state, engine_on, acc_on, crank_busy, gear_sel, gear_limit, fault_nofuel};
  endfunction

  task automatic model_reset();
    m_ps = P_OFF; m_crank_done = 0; m_fault = 0; m_gear = G_P; m_lim = MAXG;
    m_start_prev = 1'b1; m_up_prev = 1'b1; m_dn_prev = 1'b1;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit pressed, ready, has_fuel, stopped;
    int old_ps;
    old_ps   = m_ps;
    pressed  = key_start && !m_start_prev;
    ready    = key_brake && (m_gear == G_P);
    has_fuel = (fuel != 0);
    stopped  = (speed == 0);
    if (tick) begin
      if (has_fuel) m_fault = 0;
      if (m_ps == P_OFF && pressed) m_ps = (ready && has_fuel) ? P_CRANK : P_ACC;
      else if (m_ps == P_ACC && pressed) begin
        if (!ready) m_ps = P_OFF;
        else if (has_fuel) m_ps = P_CRANK;
      end else if (m_ps == P_CRANK) begin
        if (!key_brake || !has_fuel) begin m_ps = P_ACC; m_crank_done = 0; end
        else begin
          m_crank_done++;
          if (m_crank_done == CRANKS) begin m_ps = P_RUN; m_crank_done = 0; end
        end
      end else if (m_ps == P_RUN) begin
        if (!has_fuel) begin m_ps = P_ACC; m_fault = 1; end
        else if (pressed && stopped) m_ps = P_OFF;
      end
      m_start_prev = key_start;
    end
    if (key_park) m_gear = G_P;
    else if (key_neutral) m_gear = G_N;
    else if (low_mode) begin
      if (lim_up && !m_up_prev) m_lim = (m_lim + 1 > MAXG) ? MAXG : m_lim + 1;
      else if (lim_dn && !m_dn_prev) m_lim = (m_lim - 1 < 1) ? 1 : m_lim - 1;
    end else if (key_rev || key_drive) begin
      if (stopped && (m_gear != G_P || key_brake)) m_gear = key_rev ? G_R : G_D;
    end
    if (old_ps == P_RUN && m_ps == P_OFF) m_gear = expected_auto_park_gear(m_gear);
    m_up_prev = lim_up;
    m_dn_prev = lim_dn;
  endtask

  task automatic clk_step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_step();
    tick = 1'b1;
    clk_step();
    tick = 1'b0;
    clk_step();
  endtask

  task automatic test_reset();
    key_start = 1'b1; lim_up = 1'b1; key_brake = 1'b1; fuel = 8'd50;
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (dut_vec() !== model_vec()) begin
      errors++; $display("FAIL reset_state: got %h expected %h", dut_vec(), model_vec());
    end
    checks++;
    if (gear_limit !== 3'd3 || gear_sel !== 4'd3 || power_state !== 2'd0) begin
      errors++; $display("FAIL reset_consts: got lim %0d gear %0d ps %0d", gear_limit, gear_sel, power_state);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    tick_step();
    checks++;
    if (power_state !== 2'd0) begin
      errors++; $display("FAIL held_key_not_edge: got %0d expected 0", power_state);
    end
    key_start = 1'b0; lim_up = 1'b0;
    tick_step();
  endtask

  task automatic test_crank();
    key_brake = 1'b1; fuel = 8'd50; speed = 8'd0;
    key_start = 1'b1;
    tick_step();
    checks++;
    if (power_state !== 2'd3 || crank_busy !== 1'b1) begin
      errors++; $display("FAIL crank_enter: got %0d expected 3", power_state);
    end
    key_start = 1'b0;
    for (int i = 0; i < CRANKS - 1; i++) begin
      tick_step();
      checks++;
      if (power_state !== 2'd3) begin
        errors++; $display("FAIL crank_hold%0d: got %0d expected 3", i, power_state);
      end
    end
    tick_step();
    checks++;
    if (power_state !== 2'd2 || engine_on !== 1'b1 || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL crank_run: got %h expected %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_nofuel();
    speed = 8'd0; fuel = 8'd0;
    tick_step();
    checks++;
    if (power_state !== 2'd1 || fault_nofuel !== 1'b1) begin
      errors++; $display("FAIL nofuel_trip: got ps %0d flag %0d expected 1 1", power_state, fault_nofuel);
    end
    fuel = 8'd10;
    clk_step();
    checks++;
    if (fault_nofuel !== 1'b1) begin
      errors++; $display("FAIL nofuel_sticky: got %0d expected 1", fault_nofuel);
    end
    tick_step();
    checks++;
    if (fault_nofuel !== 1'b0 || power_state !== 2'd1) begin
      errors++; $display("FAIL nofuel_clear: got flag %0d ps %0d expected 0 1", fault_nofuel, power_state);
    end
  endtask

  task automatic test_crank_abort();
    key_start = 1'b1; tick_step(); key_start = 1'b0;
    tick_step();
    key_brake = 1'b0;
    tick_step();
    checks++;
    if (power_state !== 2'd1 || crank_busy !== 1'b0) begin
      errors++; $display("FAIL abort_brake: got %0d expected 1", power_state);
    end
    key_brake = 1'b1; key_start = 1'b1; tick_step(); key_start = 1'b0;
    checks++;
    if (power_state !== 2'd3) begin
      errors++; $display("FAIL recrank: got %0d expected 3", power_state);
    end
    tick_step(); tick_step();
    fuel = 8'd0;
    tick_step();
    checks++;
    if (power_state !== 2'd1 || fault_nofuel !== 1'b0) begin
      errors++; $display("FAIL abort_wins: got ps %0d flag %0d expected 1 0", power_state, fault_nofuel);
    end
    fuel = 8'd50;
    key_start = 1'b1; tick_step(); key_start = 1'b0;
    for (int i = 0; i < CRANKS; i++) tick_step();
    checks++;
    if (dut_vec() !== model_vec() || power_state !== 2'd2) begin
      errors++; $display("FAIL abort_then_run: got %h expected %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_gear();
    speed = 8'd20; key_brake = 1'b1; key_drive = 1'b1;
    clk_step();
    checks++;
    if (gear_sel !== 4'd3) begin
      errors++; $display("FAIL drive_moving: got %0d expected 3", gear_sel);
    end
    speed = 8'd0; key_brake = 1'b0;
    clk_step();
    checks++;
    if (gear_sel !== 4'd3) begin
      errors++; $display("FAIL shift_lock: got %0d expected 3", gear_sel);
    end
    key_brake = 1'b1;
    clk_step();
    checks++;
    if (gear_sel !== 4'd12) begin
      errors++; $display("FAIL drive_ok: got %0d expected 12", gear_sel);
    end
    key_drive = 1'b0; key_brake = 1'b0; key_rev = 1'b1;
    clk_step();
    checks++;
    if (gear_sel !== 4'd6) begin
      errors++; $display("FAIL rev_from_d: got %0d expected 6", gear_sel);
    end
    key_drive = 1'b1; key_neutral = 1'b1;
    clk_step();
    checks++;
    if (gear_sel !== 4'd9) begin
      errors++; $display("FAIL neutral_prio: got %0d expected 9", gear_sel);
    end
    key_neutral = 1'b0; key_rev = 1'b0;
    clk_step();
    key_drive = 1'b0; key_brake = 1'b1;
    checks++;
    if (gear_sel !== 4'd12 || dut_vec() !== model_vec()) begin
      errors++; $display("FAIL back_to_d: got %h expected %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_run_off();
    speed = 8'd0; key_start = 1'b1;
    tick_step();
    key_start = 1'b0;
    checks++;
    if (power_state !== 2'd0 || 32'(gear_sel) !== expected_auto_park_gear(G_D)) begin
      errors++; $display("FAIL run_off: got ps %0d gear %0d expected 0 %0d",
                         power_state, gear_sel, expected_auto_park_gear(G_D));
    end
    tick_step();
  endtask

  task automatic test_low_mode();
    int gear_before;
    low_mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      lim_dn = 1'b1; clk_step(); lim_dn = 1'b0; clk_step();
    end
    checks++;
    if (gear_limit !== 3'd1) begin
      errors++; $display("FAIL lim_floor: got %0d expected 1", gear_limit);
    end
    lim_up = 1'b1;
    for (int i = 0; i < 3; i++) clk_step();
    lim_up = 1'b0; clk_step();
    checks++;
    if (gear_limit !== 3'd2) begin
      errors++; $display("FAIL lim_level_once: got %0d expected 2", gear_limit);
    end
    lim_up = 1'b1; lim_dn = 1'b1; clk_step(); lim_up = 1'b0; lim_dn = 1'b0; clk_step();
    checks++;
    if (gear_limit !== 3'd3) begin
      errors++; $display("FAIL lim_up_wins: got %0d expected 3", gear_limit);
    end
    for (int i = 0; i < 4; i++) begin
      lim_up = 1'b1; clk_step(); lim_up = 1'b0; clk_step();
    end
    checks++;
    if (gear_limit !== 3'd3) begin
      errors++; $display("FAIL lim_ceiling: got %0d expected 3", gear_limit);
    end
    gear_before = m_gear;
    key_rev = 1'b1; key_brake = 1'b1; speed = 8'd0;
    clk_step();
    checks++;
    if (32'(gear_sel) !== gear_before) begin
      errors++; $display("FAIL low_mode_rev: got %0d expected %0d", gear_sel, gear_before);
    end
    key_rev = 1'b0; low_mode = 1'b0;
    clk_step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      tick        = ($urandom_range(0, 2) == 0);
      key_start   = ($urandom_range(0, 3) == 0);
      key_brake   = ($urandom_range(0, 5) != 0);
      key_park    = ($urandom_range(0, 15) == 0);
      key_neutral = ($urandom_range(0, 19) == 0);
      key_rev     = ($urandom_range(0, 9) == 0);
      key_drive   = ($urandom_range(0, 7) == 0);
      low_mode    = ($urandom_range(0, 5) == 0);
      lim_up      = ($urandom_range(0, 2) == 0);
      lim_dn      = ($urandom_range(0, 2) == 0);
      speed       = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      fuel        = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      clk_step();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL random_cycle%0d: got %h expected %h", i, dut_vec(), model_vec());
      end
    end
    tick = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_crank();
    test_nofuel();
    test_crank_abort();
    test_gear();
    test_run_off();
    test_low_mode();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
